// File: rtl/mult_shift_add.sv
// Iterative 16x16 unsigned shift-and-add multiplier. The accumulation adder is
// external: the block presents add_a/add_b and consumes add_sum each RUN cycle.
module mult_shift_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [15:0] q_q, q_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  // Next-state logic: one shift-and-add step per RUN cycle, fixed 16 steps.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = {16'b0, mcand};
          q_d     = mplier;
          acc_d   = 32'h0;
          cnt_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = add_sum;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Last step: the adder output is already the final product.
          product_d = add_sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= 32'h0;
      q_q       <= 16'h0;
      acc_q     <= 32'h0;
      cnt_q     <= 4'd0;
      product_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Outputs decoded from state; adder operands are forced to zero outside RUN.
  always_comb begin
    busy    = (state_q == StRun);
    done    = (state_q == StDone);
    product = product_q;
    add_a   = 32'h0;
    add_b   = 32'h0;
    if (state_q == StRun) begin
      add_a = acc_q;
      add_b = q_q[0] ? m_q : 32'h0;
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed and random checks for mult_shift_add with a behavioural adder.
module tb_mult_shift_add;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] held_prod;

  mult_shift_add dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  // External adder model.
  assign add_sum = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge. Checks 16 RUN cycles, the done
  // cycle and the following idle cycle; optionally swaps operands mid-run.
  task automatic expect_run(input logic [31:0] exp, input logic zero_b,
                            input logic chg, input logic [15:0] ca, input logic [15:0] cb);
    for (int k = 0; k < 16; k++) begin
      if (chg && k == 4) begin
        mcand  = ca;
        mplier = cb;
      end
      check("busy_run", {31'b0, busy}, 32'd1);
      check("done_run", {31'b0, done}, 32'd0);
      check("prod_hold_run", product, held_prod);
      if (zero_b) check("add_b_zero", add_b, 32'h0);
      step();
    end
    check("done_pulse", {31'b0, done}, 32'd1);
    check("busy_done", {31'b0, busy}, 32'd0);
    check("product", product, exp);
    check("add_a_done", add_a, 32'h0);
    check("add_b_done", add_b, 32'h0);
    held_prod = exp;
    step();
    check("done_width", {31'b0, done}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("prod_hold_idle", product, exp);
  endtask

  // Issue one multiply with a single-cycle start pulse.
  task automatic mult_op(input logic [15:0] a, input logic [15:0] b, input logic zero_b);
    logic [31:0] exp;
    exp    = {16'b0, a} * {16'b0, b};
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    expect_run(exp, zero_b, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    n_checks  = 0;
    n_errors  = 0;
    held_prod = 32'h0;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = 16'h0;
    mplier = 16'h0;
    step();
    step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", product, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    rst = 1'b0;
    step();

    // Idle without start stays idle.
    check("idle_busy", {31'b0, busy}, 32'd0);

    mult_op(16'd3, 16'd5, 1'b0);
    check("3x5", product, 32'h0000000F);
    mult_op(16'hFFFF, 16'hFFFF, 1'b0);
    check("ffffxffff", product, 32'hFFFE0001);
    mult_op(16'h8000, 16'h0002, 1'b0);
    check("8000x2", product, 32'h00010000);
    mult_op(16'h1234, 16'h0000, 1'b1);
    check("1234x0", product, 32'h0);

    // start held high; operands change mid-run, next multiply follows done.
    mcand  = 16'd11;
    mplier = 16'd13;
    start  = 1'b1;
    step();
    expect_run(32'd143, 1'b0, 1'b1, 16'd300, 16'd400);
    step();
    expect_run(32'd120000, 1'b0, 1'b0, 16'h0, 16'h0);
    start = 1'b0;
    step();

    // Reset in the middle of a run discards it and never pulses done.
    mcand  = 16'd100;
    mplier = 16'd200;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    held_prod = 32'h0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_product", product, 32'h0);
    check("rst_mid_add_a", add_a, 32'h0);
    for (int k = 0; k < 20; k++) begin
      check("no_done_after_rst", {31'b0, done}, 32'd0);
      step();
    end

    // start coincident with reset is ignored.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("start_with_rst", {31'b0, busy}, 32'd0);
    step();
    check("start_with_rst_idle", {31'b0, busy}, 32'd0);

    mult_op(16'd7, 16'd9, 1'b0);
    check("7x9", product, 32'h0000003F);

    // Back-to-back random operands.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      mult_op(ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
